// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a single-port RAM into a valid/ready stream FIFO.
// The RAM port is shared between pushes and refills of a single registered
// output slot. A refill always takes the port, so a push stalls for that
// cycle. Total capacity is DEPTH words in RAM plus the output slot.
module ram_fifo_ctrl #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [BUS_WIDTH-1:0]     in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [BUS_WIDTH-1:0]     out_data,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic [ADDRESS_WIDTH-1:0] ram_ad,
  output logic                     ram_st,
  output logic [BUS_WIDTH-1:0]     ram_x,
  input  logic [BUS_WIDTH-1:0]     ram_o
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH+1)'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH:0]   mem_count;
  logic                     rd;
  logic                     wr;

  // Port arbitration: refill of the output slot wins over a push.
  always_comb begin
    rd       = rst_n && (mem_count != '0) && (!out_valid || out_ready);
    in_ready = rst_n && (mem_count != DEPTH_CNT) && !rd;
    wr       = in_valid && in_ready;
    ram_ad   = rd ? rd_ptr : wr_ptr;
    ram_st   = wr;
    ram_x    = in_data;
  end

  // Pointers, RAM occupancy and the registered output slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (rd) begin
        out_data  <= ram_o;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // rd and wr never coincide, so the count moves by at most one.
      case ({rd, wr})
        2'b10:   mem_count <= mem_count - 1'b1;
        2'b01:   mem_count <= mem_count + 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  assign full  = (mem_count == DEPTH_CNT);
  assign level = mem_count + {{ADDRESS_WIDTH{1'b0}}, out_valid};
  assign empty = (level == '0);

endmodule
